// File: rtl/uart_packet_receiver.sv
// Reassembles 4-byte score frames (ID, points MSB..LSB) from a UART byte stream.
// Flags idle markers, illegal IDs and inter-byte timeouts.
module uart_packet_receiver #(
  parameter int unsigned BYTE_TIMEOUT = 100000,
  parameter int unsigned CNT_W        = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  board_ID_rx,
  output logic [23:0] points_rx,
  output logic        packet_valid,
  output logic        link_idle,
  output logic        frame_error,
  output logic        busy
);

  typedef enum logic [1:0] {
    WAIT_ID,
    GET_B2,
    GET_B1,
    GET_B0
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BYTE_TIMEOUT - 1);
  localparam logic [7:0]       IDLE_ID  = 8'hFF;
  localparam logic [7:0]       BAD_ID   = 8'h00;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        id_sh_q, id_sh_d;
  logic [23:0]       pts_sh_q, pts_sh_d;
  logic [7:0]        board_q, board_d;
  logic [23:0]       points_q, points_d;
  logic              pv_q, pv_d;
  logic              idle_q, idle_d;
  logic              ferr_q, ferr_d;
  logic              busy_q, busy_d;
  logic              timed_out;

  // Expiry only matters mid-frame and loses to a byte arriving the same cycle.
  assign timed_out = (state_q != WAIT_ID) && !rx_valid && (cnt_q == CNT_LAST);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    id_sh_d  = id_sh_q;
    pts_sh_d = pts_sh_q;
    board_d  = board_q;
    points_d = points_q;
    pv_d     = 1'b0;
    idle_d   = idle_q;
    ferr_d   = 1'b0;
    unique case (state_q)
      WAIT_ID: begin
        cnt_d = '0;
        if (rx_valid) begin
          if (rx_data == IDLE_ID) begin
            idle_d = 1'b1;
          end else if (rx_data == BAD_ID) begin
            ferr_d = 1'b1;
          end else begin
            id_sh_d = rx_data;
            state_d = GET_B2;
          end
        end
      end
      GET_B2: begin
        if (rx_valid) begin
          pts_sh_d[23:16] = rx_data;
          cnt_d           = '0;
          state_d         = GET_B1;
        end
      end
      GET_B1: begin
        if (rx_valid) begin
          pts_sh_d[15:8] = rx_data;
          cnt_d          = '0;
          state_d        = GET_B0;
        end
      end
      GET_B0: begin
        if (rx_valid) begin
          pts_sh_d[7:0] = rx_data;
          cnt_d         = '0;
          board_d       = id_sh_q;
          points_d      = {pts_sh_q[23:8], rx_data};
          pv_d          = 1'b1;
          idle_d        = 1'b0;
          state_d       = WAIT_ID;
        end
      end
      default: state_d = WAIT_ID;
    endcase
    if (state_q != WAIT_ID && !rx_valid) begin
      if (timed_out) begin
        cnt_d   = '0;
        ferr_d  = 1'b1;
        state_d = WAIT_ID;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    busy_d = (state_d != WAIT_ID);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= WAIT_ID;
      cnt_q    <= '0;
      id_sh_q  <= '0;
      pts_sh_q <= '0;
      board_q  <= '0;
      points_q <= '0;
      pv_q     <= 1'b0;
      idle_q   <= 1'b0;
      ferr_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      id_sh_q  <= id_sh_d;
      pts_sh_q <= pts_sh_d;
      board_q  <= board_d;
      points_q <= points_d;
      pv_q     <= pv_d;
      idle_q   <= idle_d;
      ferr_q   <= ferr_d;
      busy_q   <= busy_d;
    end
  end

  assign board_ID_rx  = board_q;
  assign points_rx    = points_q;
  assign packet_valid = pv_q;
  assign link_idle    = idle_q;
  assign frame_error  = ferr_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_uart_packet_receiver.sv
// Bench for uart_packet_receiver: directed plan steps plus random byte traffic
// compared every cycle against a frame-level reference model.
module tb_uart_packet_receiver;

  localparam int BT = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic [7:0]  board_ID_rx;
  logic [23:0] points_rx;
  logic        packet_valid;
  logic        link_idle;
  logic        frame_error;
  logic        busy;

  uart_packet_receiver #(.BYTE_TIMEOUT(BT), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .board_ID_rx(board_ID_rx), .points_rx(points_rx),
    .packet_valid(packet_valid), .link_idle(link_idle),
    .frame_error(frame_error), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int pv_seen = 0;
  int fe_seen = 0;

  // Reference model: bytes of the frame in progress and silence since last byte
  logic [7:0]  fq[$];
  int          silent;
  logic [7:0]  m_id;
  logic [23:0] m_pts;
  logic        m_pv, m_idle, m_fe;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    fq.delete();
    silent = 0;
    m_id = '0; m_pts = '0;
    m_pv = 0; m_idle = 0; m_fe = 0;
  endtask

  task automatic model_step(input logic v, input logic [7:0] d);
    m_pv = 0;
    m_fe = 0;
    if (v) begin
      silent = 0;
      if (fq.size() == 0) begin
        if (d == 8'hFF) m_idle = 1;
        else if (d == 8'h00) m_fe = 1;
        else fq.push_back(d);
      end else begin
        fq.push_back(d);
        if (fq.size() == 4) begin
          m_id   = fq[0];
          m_pts  = {fq[1], fq[2], fq[3]};
          m_pv   = 1;
          m_idle = 0;
          fq.delete();
        end
      end
    end else if (fq.size() != 0) begin
      silent++;
      if (silent == BT) begin
        m_fe = 1;
        fq.delete();
        silent = 0;
      end
    end
  endtask

  task automatic check_all(input string where);
    chk({where, ".board"}, board_ID_rx, m_id);
    chk({where, ".points"}, points_rx, m_pts);
    chk({where, ".pvalid"}, packet_valid, m_pv);
    chk({where, ".idle"}, link_idle, m_idle);
    chk({where, ".ferr"}, frame_error, m_fe);
    chk({where, ".busy"}, busy, (fq.size() != 0));
  endtask

  task automatic tick(input logic v, input logic [7:0] d);
    @(negedge clk);
    rx_valid = v;
    rx_data  = d;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    model_step(v, d);
    if (packet_valid === 1'b1) pv_seen++;
    if (frame_error === 1'b1) fe_seen++;
    check_all("cyc");
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    repeat (gap) tick(1'b0, 8'($urandom));
    tick(1'b1, b);
  endtask

  int pv0, fe0, g, r;

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    // Normal frame, 20-cycle gaps
    pv0 = pv_seen;
    send(8'h03, 20);
    chk("busy_after_b1", busy, 1);
    send(8'h01, 20);
    send(8'h86, 20);
    send(8'hA0, 20);
    chk("normal_pv_now", packet_valid, 1);
    chk("normal_id", board_ID_rx, 8'h03);
    chk("normal_pts", points_rx, 24'h0186A0);
    chk("normal_busy", busy, 0);
    tick(1'b0, 8'h00);
    chk("normal_pv_count", pv_seen - pv0, 1);

    // Idle marker, then all-0xFF payload
    send(8'hFF, 3);
    chk("idle_set", link_idle, 1);
    chk("idle_nopv", packet_valid, 0);
    send(8'h02, 2);
    send(8'hFF, 2);
    send(8'hFF, 2);
    send(8'hFF, 2);
    chk("ff_id", board_ID_rx, 8'h02);
    chk("ff_pts", points_rx, 24'hFFFFFF);
    chk("ff_idle_clr", link_idle, 0);

    // Timeout after two bytes
    send(8'h05, 4);
    send(8'h00, 1);
    fe0 = fe_seen;
    repeat (BT - 1) tick(1'b0, 8'h00);
    chk("to_not_early", fe_seen - fe0, 0);
    tick(1'b0, 8'h00);
    chk("to_fire", frame_error, 1);
    repeat (5) tick(1'b0, 8'h00);
    chk("to_once", fe_seen - fe0, 1);
    chk("to_id_kept", board_ID_rx, 8'h02);
    chk("to_pts_kept", points_rx, 24'hFFFFFF);
    send(8'h05, 1);
    send(8'h00, 1);
    send(8'h00, 1);
    send(8'h2A, 1);
    chk("to_next_pts", points_rx, 24'h00002A);

    // Byte lands exactly on the last allowed cycle
    fe0 = fe_seen;
    send(8'h09, 3);
    send(8'h11, BT - 1);
    send(8'h22, BT - 1);
    send(8'h33, BT - 1);
    chk("edge_pv", packet_valid, 1);
    chk("edge_pts", points_rx, 24'h112233);
    chk("edge_noerr", fe_seen - fe0, 0);

    // Illegal ID then two back-to-back frames
    send(8'h00, 2);
    chk("bad_id_err", frame_error, 1);
    chk("bad_id_busy", busy, 0);
    pv0 = pv_seen;
    send(8'h0A, 0); send(8'h12, 0); send(8'h34, 0); send(8'h56, 0);
    send(8'h0B, 0); send(8'h78, 0); send(8'h9A, 0); send(8'hBC, 0);
    chk("b2b_id", board_ID_rx, 8'h0B);
    chk("b2b_pts", points_rx, 24'h789ABC);
    tick(1'b0, 8'h00);
    chk("b2b_pv_count", pv_seen - pv0, 2);

    // Reset mid-frame
    send(8'h44, 2);
    send(8'h55, 2);
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    check_all("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    send(8'h07, 2);
    send(8'h00, 2);
    send(8'h10, 2);
    send(8'h00, 2);
    chk("rst_id", board_ID_rx, 8'h07);
    chk("rst_pts", points_rx, 24'h001000);

    // Random traffic including long gaps, idle markers and illegal IDs
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 19);
      if (r == 0) g = BT + $urandom_range(0, 3);
      else if (r == 1) g = BT - 1;
      else g = $urandom_range(0, 4);
      send(8'($urandom), g);
    end
    repeat (BT + 2) tick(1'b0, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_packet_receiver.md
Name: uart_packet_receiver

Overview:
Receive-side counterpart of the board's 4-byte score transmitter. Takes the byte stream from the UART RX core (one strobe per byte), reassembles frames of board ID, points[23:16], points[15:8] and points[7:0], and presents the peer's board ID and 24-bit score to the game/display logic. Also flags idle markers (0xFF in the ID slot), and flags frame errors and inter-byte timeouts.

Parameters:
BYTE_TIMEOUT, 100000, maximum clk cycles allowed between consecutive bytes inside one frame before the partial frame is dropped.
CNT_W, 17, width of the timeout counter; must satisfy 2^CNT_W > BYTE_TIMEOUT.

Ports:
clk  input  1  system clock; single clock domain.
rst  input  1  asynchronous, active-high reset.
rx_data  input  8  byte from the UART RX core; valid only when rx_valid=1.
rx_valid  input  1  one-cycle strobe, one per received byte.
board_ID_rx  output  8  board ID of the last complete valid frame.
points_rx  output  24  score of the last complete valid frame.
packet_valid  output  1  one-cycle pulse when board_ID_rx/points_rx update.
link_idle  output  1  level; peer is sending idle markers (0xFF).
frame_error  output  1  one-cycle pulse on an illegal ID byte or an inter-byte timeout.
busy  output  1  high while a frame is partially received (state other than WAIT_ID).

Behaviour:
- Reset (async, immediate): state=WAIT_ID, board_ID_rx=0, points_rx=0, packet_valid=0, link_idle=0, frame_error=0, busy=0, timeout counter=0, shadow registers=0.
- All outputs are registered. Nothing is combinational from rx_data or rx_valid to any output.
- States: WAIT_ID, GET_B2, GET_B1, GET_B0.
- WAIT_ID, rx_valid=1:
  - rx_data=0xFF: idle marker. Set link_idle=1 and stay in WAIT_ID. No pulse.
  - rx_data=0x00: illegal ID. Pulse frame_error for one cycle and stay in WAIT_ID.
  - Any other value: latch it into the shadow ID, go to GET_B2, clear the timeout counter.
- GET_B2, GET_B1, GET_B0, rx_valid=1:
  - Every value 0x00..0xFF is legal payload, including 0xFF.
  - The byte goes into shadow points[23:16], [15:8], [7:0] respectively (MSB first).
  - The timeout counter clears and the state advances.
- Frame completion: on the rx_valid cycle in GET_B0, the state returns to WAIT_ID. On the next clock edge:
  - board_ID_rx and points_rx load the shadow values, with the final byte included.
  - packet_valid=1 for exactly one cycle.
  - link_idle clears to 0.
  - Latency: outputs valid one clk after the 4th rx_valid.
- board_ID_rx and points_rx hold between frames. A partial or aborted frame never changes them.
- Timeout: in GET_* states the counter increments each cycle with rx_valid=0. When the counter reaches BYTE_TIMEOUT-1 with rx_valid=0:
  - The partial frame is dropped and the state returns to WAIT_ID.
  - frame_error pulses once and the counter clears.
  - The counter never runs in WAIT_ID; the line may be silent indefinitely there.
- Simultaneous events: rx_valid in the same cycle the counter reaches BYTE_TIMEOUT-1 means the byte is accepted and no timeout fires.
- Back-to-back strobes on consecutive cycles must be accepted with no byte loss. A new ID byte may arrive the cycle immediately after frame completion.
- busy=1 exactly when state≠WAIT_ID (registered with the state).
- Reset asserted mid-frame discards the partial frame and clears all outputs immediately. The first byte after reset release is treated as an ID byte.

Test Plan:
- Normal frame: bytes 0x03, 0x01, 0x86, 0xA0 with 20-cycle gaps -> exactly one packet_valid pulse, 1 clk after the 4th strobe. board_ID_rx=0x03, points_rx=0x0186A0 (100000). busy is high from after byte 1 until after byte 4.
- Idle and 0xFF payload:
  - Send 0xFF -> link_idle=1 and no pulse.
  - Then send frame 0x02, 0xFF, 0xFF, 0xFF -> points_rx=0xFFFFFF, board_ID_rx=0x02, link_idle=0.
- Timeout:
  - Send 0x05, 0x00, then silence -> frame_error pulses once, BYTE_TIMEOUT cycles after the 2nd strobe. board_ID_rx and points_rx keep their prior values.
  - A following frame 0x05, 0x00, 0x00, 0x2A decodes to points_rx=0x00002A.
- Boundary: within a frame, deliver a byte on exactly the cycle the counter hits BYTE_TIMEOUT-1 -> no frame_error and the frame completes.
- Illegal ID and back-to-back: a 0x00 ID byte gives a frame_error pulse and stays in WAIT_ID. Then send two 4-byte frames on consecutive-cycle strobes -> two packet_valid pulses with correct data.
- Reset mid-frame: assert rst after 2 bytes of a frame -> all outputs are 0 immediately. After release, a full frame 0x07, 0x00, 0x10, 0x00 gives board_ID_rx=0x07 and points_rx=0x001000.
